// File: rtl/i2c_target_pkg.sv
// Shared types and bus constants for the I2C EEPROM-emulating target.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_ADDR_HI,
    ST_ADDR_HI_ACK,
    ST_ADDR_LO,
    ST_ADDR_LO_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  localparam logic CTRL_WRITE = 1'b0;
  localparam logic CTRL_READ  = 1'b1;
  localparam logic ACK        = 1'b0;
  localparam logic NACK       = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with registered edge, START and STOP strobes.
// Optional 3-sample agreement filter when I2C_TARGET_GLITCH_FILTER_EN is defined.
module i2c_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_q, sda_q, scl_d, sda_d;
  logic       scl_rise_q, scl_fall_q, start_q, stop_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
    end
  end

  always_comb begin
    scl_d = scl_q;
    sda_d = sda_q;
    if (scl_hist_q == {2{scl_sync_q[1]}}) scl_d = scl_sync_q[1];
    if (sda_hist_q == {2{sda_sync_q[1]}}) sda_d = sda_sync_q[1];
  end
`else
  assign scl_d = scl_sync_q[1];
  assign sda_d = sda_sync_q[1];
`endif

  // Strobes are registered alongside the level so sda_o is aligned with them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      scl_rise_q <= ~scl_q & scl_d;
      scl_fall_q <= scl_q & ~scl_d;
      start_q    <= scl_q & scl_d & sda_q & ~sda_d;
      stop_q     <= scl_q & scl_d & ~sda_q & sda_d;
    end
  end

  assign sda_o      = sda_q;
  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;

endmodule

// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a 24-series EEPROM with two address bytes and write-cycle busy.
// Glitch filter on the bus lines enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_eeprom_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  DEVICE_ADDR      = 7'b1010000,
  parameter int unsigned MEM_ADDR_BITS    = 12,
  parameter int unsigned PAGE_SIZE        = 64,
  parameter int unsigned WRITE_CYCLE_CLKS = 5000
) (
  input  logic        csi_clk,
  input  logic        rsi_reset,
  input  logic        coe_conduit_serialClock,
  inout  wire         coe_conduit_serialData,
  input  logic        coe_conduit_writeProtect,
  output logic        busy,
  output logic [15:0] lastAddr
);

  localparam int unsigned PAGE_BITS = $clog2(PAGE_SIZE);
  localparam int unsigned HI_BITS   = MEM_ADDR_BITS - 8;
  localparam int unsigned CNT_W     = $clog2(WRITE_CYCLE_CLKS + 1);

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_line_sync (
    .clk_i      (csi_clk),
    .rst_ni     (rsi_reset),
    .scl_i      (coe_conduit_serialClock),
    .sda_i      (coe_conduit_serialData),
    .sda_o      (sda_lvl),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  state_t                   state_q, state_d;
  logic [3:0]               bitcnt_q, bitcnt_d;
  logic [7:0]               shift_q, shift_d;
  logic [HI_BITS-1:0]       hi_q, hi_d;
  logic [MEM_ADDR_BITS-1:0] ptr_q, ptr_d;
  logic                     rw_q, rw_d, wrote_q, wrote_d, sda_oe_q, sda_oe_d;
  logic [CNT_W-1:0]         busy_cnt_q, busy_cnt_d;
  logic [7:0]               mem [0:(1 << MEM_ADDR_BITS)-1];
  logic [7:0]               rx_byte, rd_byte;
  logic                     rx_state, byte_done, mem_we, load_rd;

  assign rx_byte   = {shift_q[6:0], sda_lvl};
  assign rd_byte   = mem[ptr_q];
  assign rx_state  = (state_q == ST_DEV_ADDR) || (state_q == ST_ADDR_HI) ||
                     (state_q == ST_ADDR_LO)  || (state_q == ST_WR_DATA);
  assign byte_done = rx_state && scl_rise && (bitcnt_q == 4'd7);

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    hi_d       = hi_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    wrote_d    = wrote_q;
    sda_oe_d   = sda_oe_q;
    mem_we     = 1'b0;
    load_rd    = 1'b0;
    busy_cnt_d = (busy_cnt_q != '0) ? busy_cnt_q - 1'b1 : busy_cnt_q;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      wrote_d  = 1'b0;
      if (wrote_q) busy_cnt_d = CNT_W'(WRITE_CYCLE_CLKS);
    end else if (start_det) begin
      state_d  = ST_DEV_ADDR;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
      wrote_d  = 1'b0;
    end else begin
      if (rx_state && scl_rise) begin
        shift_d  = rx_byte;
        bitcnt_d = (bitcnt_q == 4'd7) ? 4'd0 : bitcnt_q + 4'd1;
      end
      unique case (state_q)
        ST_DEV_ADDR: if (byte_done) begin
          rw_d    = rx_byte[0];
          state_d = (rx_byte[7:1] == DEVICE_ADDR && !busy) ? ST_DEV_ACK : ST_IGNORE;
        end
        ST_ADDR_HI: if (byte_done) begin
          hi_d    = rx_byte[HI_BITS-1:0];
          state_d = ST_ADDR_HI_ACK;
        end
        ST_ADDR_LO: if (byte_done) begin
          ptr_d   = {hi_q, rx_byte};
          state_d = ST_ADDR_LO_ACK;
        end
        ST_WR_DATA: if (byte_done) begin
          if (!coe_conduit_writeProtect) begin
            mem_we  = 1'b1;
            wrote_d = 1'b1;
          end
          ptr_d   = {ptr_q[MEM_ADDR_BITS-1:PAGE_BITS], ptr_q[PAGE_BITS-1:0] + 1'b1};
          state_d = ST_WR_ACK;
        end
        // First SCL fall in an ACK state drives ACK, the second releases and moves on.
        ST_DEV_ACK, ST_ADDR_HI_ACK, ST_ADDR_LO_ACK, ST_WR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            bitcnt_d = '0;
            if (state_q == ST_DEV_ADDR || state_q == ST_DEV_ACK) begin
              if (rw_q == CTRL_READ) load_rd = 1'b1;
              else                   state_d = ST_ADDR_HI;
            end else if (state_q == ST_ADDR_HI_ACK) begin
              state_d = ST_ADDR_LO;
            end else begin
              state_d = ST_WR_DATA;
            end
          end
        end
        ST_RD_DATA: begin
          if (scl_rise) bitcnt_d = bitcnt_q + 4'd1;
          if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              state_d  = ST_RD_ACK;
              sda_oe_d = 1'b0;
              bitcnt_d = '0;
            end else begin
              shift_d  = {shift_q[6:0], shift_q[7]};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise && sda_lvl == NACK) state_d = ST_IGNORE;
          else if (scl_fall)               load_rd = 1'b1;
        end
        ST_IDLE, ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
      if (load_rd) begin
        shift_d  = rd_byte;
        sda_oe_d = ~rd_byte[7];
        ptr_d    = ptr_q + 1'b1;
        bitcnt_d = '0;
        state_d  = ST_RD_DATA;
      end
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset) begin
    if (!rsi_reset) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      hi_q       <= '0;
      ptr_q      <= '0;
      rw_q       <= CTRL_WRITE;
      wrote_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      hi_q       <= hi_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      wrote_q    <= wrote_d;
      sda_oe_q   <= sda_oe_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  always_ff @(posedge csi_clk) begin
    if (mem_we) mem[ptr_q] <= rx_byte;
  end

  assign coe_conduit_serialData = sda_oe_q ? ACK : 1'bz;
  assign busy                   = (busy_cnt_q != '0);
  assign lastAddr               = 16'(ptr_q);

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Directed bench for i2c_eeprom_target: byte/page write, busy, random read, write protect, reset.
module tb_i2c_eeprom_target;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        wp = 1'b0;
  logic        busy;
  logic [15:0] last_addr;
  wire         sda_bus;

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;

  assign sda_bus = sda_m ? 1'bz : 1'b0;
  pullup (sda_bus);

  always #5 clk = ~clk;

  always @(negedge clk) if (busy) busy_cycles++;

  i2c_eeprom_target #(
    .DEVICE_ADDR      (7'b1010000),
    .MEM_ADDR_BITS    (12),
    .PAGE_SIZE        (64),
    .WRITE_CYCLE_CLKS (5000)
  ) dut (
    .csi_clk                  (clk),
    .rsi_reset                (rst_n),
    .coe_conduit_serialClock  (scl),
    .coe_conduit_serialData   (sda_bus),
    .coe_conduit_writeProtect (wp),
    .busy                     (busy),
    .lastAddr                 (last_addr)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(5);
    scl = 1'b1;   tick(10);
    sda_m = 1'b0; tick(10);
    scl = 1'b0;   tick(5);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(5);
    scl = 1'b1;   tick(10);
    sda_m = 1'b1; tick(10);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ackbit);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; tick(5);
      scl = 1'b1;   tick(10);
      scl = 1'b0;   tick(5);
    end
    sda_m = 1'b1; tick(5);
    scl = 1'b1;   tick(5);
    ackbit = sda_bus;
    tick(5);
    scl = 1'b0;   tick(5);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(5);
      scl = 1'b1; tick(5);
      b[i] = sda_bus;
      tick(5);
      scl = 1'b0; tick(5);
    end
    sda_m = mack; tick(5);
    scl = 1'b1;   tick(10);
    scl = 1'b0;   tick(1);
    sda_m = 1'b1; tick(4);
  endtask

  task automatic header(input logic [15:0] addr);
    logic a;
    i2c_start();
    write_byte(8'hA0, a); check("hdr_dev_ack", 16'(a), 16'h0);
    write_byte(addr[15:8], a); check("hdr_hi_ack", 16'(a), 16'h0);
    write_byte(addr[7:0], a); check("hdr_lo_ack", 16'(a), 16'h0);
  endtask

  task automatic read_at(input logic [15:0] addr, input logic [7:0] exp, input string tag);
    logic a;
    logic [7:0] d;
    header(addr);
    i2c_start();
    write_byte(8'hA1, a); check("rd_dev_ack", 16'(a), 16'h0);
    read_byte(1'b1, d);
    i2c_stop();
    check(tag, 16'(d), 16'(exp));
  endtask

  task automatic wait_busy_low();
    int n = 0;
    while (busy && n < 6000) begin
      tick(1);
      n++;
    end
    check("busy_timeout", 16'(busy), 16'h0);
  endtask

  initial begin
    logic a;
    logic [7:0] d;

    tick(5);
    rst_n = 1'b1;
    tick(5);
    check("reset_sda", 16'(sda_bus), 16'h1);
    check("reset_busy", 16'(busy), 16'h0);
    check("reset_lastaddr", last_addr, 16'h0000);

    // Byte write 0x22 to 0x0100
    header(16'h0100);
    busy_cycles = 0;
    write_byte(8'h22, a); check("bw_data_ack", 16'(a), 16'h0);
    check("bw_lastaddr", last_addr, 16'h0101);
    i2c_stop();
    check("bw_busy_high", 16'(busy), 16'h1);

    // Addressing during busy is NACKed and leaves the counter running
    i2c_start();
    write_byte(8'hA0, a); check("busy_nack", 16'(a), 16'h1);
    i2c_stop();
    check("busy_still_high", 16'(busy), 16'h1);
    wait_busy_low();
    check("busy_length", 16'(busy_cycles), 16'd5000);

    // Random read of 0x0100
    header(16'h0100);
    i2c_start();
    write_byte(8'hA1, a); check("rr_dev_ack", 16'(a), 16'h0);
    read_byte(1'b1, d);
    check("rr_data", 16'(d), 16'h0022);
    i2c_stop();
    check("rr_sda_released", 16'(sda_bus), 16'h1);
    check("rr_lastaddr", last_addr, 16'h0101);

    // Page wrap: 0x13E, 0x13F, then back to 0x100
    header(16'h013E);
    write_byte(8'h11, a); check("pw_ack0", 16'(a), 16'h0);
    write_byte(8'h22, a); check("pw_ack1", 16'(a), 16'h0);
    write_byte(8'h33, a); check("pw_ack2", 16'(a), 16'h0);
    i2c_stop();
    check("pw_lastaddr", last_addr, 16'h0101);
    wait_busy_low();
    header(16'h013E);
    i2c_start();
    write_byte(8'hA1, a); check("pw_rd_ack", 16'(a), 16'h0);
    read_byte(1'b0, d); check("pw_13E", 16'(d), 16'h0011);
    read_byte(1'b1, d); check("pw_13F", 16'(d), 16'h0022);
    i2c_stop();
    read_at(16'h0100, 8'h33, "pw_100");

    // Write protect keeps prior contents and does not start busy
    header(16'h0200);
    write_byte(8'h77, a); check("wp_pre_ack", 16'(a), 16'h0);
    i2c_stop();
    wait_busy_low();
    wp = 1'b1;
    header(16'h0200);
    write_byte(8'h55, a); check("wp_data_ack", 16'(a), 16'h0);
    i2c_stop();
    tick(10);
    check("wp_no_busy", 16'(busy), 16'h0);
    wp = 1'b0;
    read_at(16'h0200, 8'h77, "wp_unchanged");

    // Foreign control byte: NACK and no drive until STOP
    i2c_start();
    write_byte(8'hA2, a); check("foreign_nack", 16'(a), 16'h1);
    read_byte(1'b1, d); check("foreign_no_drive", 16'(d), 16'h00FF);
    i2c_stop();

    // Reset while the target drives bit 7 (0) of 0x33
    header(16'h0100);
    i2c_start();
    write_byte(8'hA1, a); check("rst_dev_ack", 16'(a), 16'h0);
    check("rst_bit7_driven", 16'(sda_bus), 16'h0);
    rst_n = 1'b0;
    #1;
    check("rst_sda_release", 16'(sda_bus), 16'h1);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    check("rst_lastaddr", last_addr, 16'h0000);
    check("rst_busy", 16'(busy), 16'h0);
    i2c_stop();
    read_at(16'h013F, 8'h22, "post_rst_read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_target.md
# i2c_eeprom_target

I2C target that emulates a 24-series serial EEPROM: device address 7'b1010000, two address bytes, byte and sequential write, current-address and random read. It is the far end of the serial bus driven by the team's Eeprom Avalon-MM I2C master. It serves as a synthesizable bus partner for board bring-up and as the responder in closed-loop benches. Memory is an internal byte array, and the block models a write-cycle busy time after each write.

## Interface
- DEVICE_ADDR, 7'b1010000, 7-bit target address matched against control-byte bits [7:1]
- MEM_ADDR_BITS, 12, implemented memory depth 2**MEM_ADDR_BITS bytes; upper received address bits ignored
- PAGE_SIZE, 64, write page in bytes (power of 2); sequential writes wrap within a page
- WRITE_CYCLE_CLKS, 5000, csi_clk cycles of busy after a write STOP
- csi_clk  in  1  system clock; must be ≥16× SCL frequency
- rsi_reset  in  1  asynchronous, active-low reset
- coe_conduit_serialClock  in  1  SCL (target never stretches)
- coe_conduit_serialData  inout  1  SDA, open-drain: driven 1'b0 or 1'bz only
- coe_conduit_writeProtect  in  1  high = memory writes inhibited
- busy  out  1  write cycle in progress
- lastAddr  out  16  current internal address pointer, zero-extended

## Operation
- SCL/SDA pass through 2-FF synchronizers; edges are detected on the synchronized values.
- START is SDA falling while SCL is high; STOP is SDA rising while SCL is high. Both are legal in any state.
- START (including repeated) → DEV_ADDR, bit counter = 0. STOP → IDLE. STOP after ≥1 accepted write data byte with writeProtect low starts the busy counter.
- States: IDLE, DEV_ADDR, DEV_ACK, ADDR_HI, ADDR_HI_ACK, ADDR_LO, ADDR_LO_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- Bits are sampled on SCL rise, MSB first. SDA is changed only on SCL fall.
- DEV_ADDR: after 8 bits, if [7:1] = DEVICE_ADDR and busy = 0 → ACK (SDA low for the 9th clock). Otherwise NACK → IGNORE until the next START or STOP.
- R/W = 0 → ADDR_HI → ADDR_LO, each ACKed; the pointer loads {hi, lo}[MEM_ADDR_BITS-1:0] → WR_DATA.
- WR_DATA byte: ACK always. Written to mem[pointer] only when writeProtect is low, sampled at the byte's 8th SCL rise. Pointer low log2(PAGE_SIZE) bits then increment with wrap; upper bits unchanged.
- R/W = 1 → RD_DATA: the shift register loads mem[pointer] on the SCL fall ending DEV_ACK/RD_ACK. The pointer increments by 1 with wrap across the full array.
- RD_ACK: master SDA low → next byte. Master high (NACK) → IGNORE and release SDA.
- Random read = write header (address bytes, no data) + repeated START + read. The address set by the header is kept.
- busy counts WRITE_CYCLE_CLKS down to 0; busy = 1 while nonzero.

## Timing
- Reset values: SDA released (z), busy = 0, lastAddr = 0, state IDLE, pointer 0, busy counter 0. Memory contents are not reset.
- Reset mid-transfer releases SDA asynchronously.
- Condition detection latency: 3 csi_clk from the pin (2 sync + 1 edge register).
- ACK/data drive is asserted ≤4 csi_clk after SCL fall and held until the SCL fall after the 9th/8th bit.
- Write commits 1 csi_clk after the detected 8th SCL rise. lastAddr updates in the same cycle as the pointer.
- busy rises 1 csi_clk after STOP detection and falls exactly WRITE_CYCLE_CLKS cycles later.
- Simultaneous STOP and busy expiry: busy restarts.
- START during busy: address NACKed, busy counter unaffected.

## Configuration
- I2C_TARGET_GLITCH_FILTER_EN defined: SCL and SDA each pass a 3-sample agreement filter after the synchronizer. The filtered value changes only when 3 consecutive samples agree; detection latency becomes 5 csi_clk and pulses <3 csi_clk are rejected.
- Not defined: synchronizer only; latency 3 csi_clk.

## Structure
- i2c_target_pkg: state enum, CTRL_WRITE/CTRL_READ bit constants, ACK = 1'b0 / NACK = 1'b1 constants.
- Sub-module i2c_line_sync: sync + optional filter + rise/fall/START/STOP strobes for both lines. Instantiated once.
- Top: FSM, bit counter, shift register, pointer, memory array, busy counter.

## Test plan
- Byte write 0xA0, 0x01, 0x00, 0x22, STOP → four ACKs, mem[0x100] = 0x22, busy high for 5000 clk.
- During busy, START + 0xA0 → NACK on 9th clock. After busy falls, same byte → ACK.
- Random read: 0xA0 0x01 0x00, repeated START, 0xA1 → target shifts 0x22. Master NACK + STOP → SDA released, lastAddr = 0x101.
- Page wrap: address 0x013E, write 0x11 0x22 0x33 → bytes land at 0x13E, 0x13F, 0x100.
- writeProtect = 1, write 0x55 to 0x0200 → all bytes ACKed, mem[0x200] unchanged, busy stays 0.
- Control byte 0xA2 → NACK, no SDA drive until STOP. Reset asserted mid-read-byte → SDA z within 0 clk, state IDLE.
